// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard sequencer.
//  - hz_state_e : sequencer state (running, waiting on multi-cycle EX op,
//                 waiting on data memory)
//  - hz_ctrl_t  : bundle of the eight pipeline hold/clear controls
//  - load_use_hit() : load-use dependency test between the EX load and ID
package hazard_ctrl_pkg;

    localparam int HZ_WDOG_DEFAULT   = 1024;
    localparam int HZ_PERF_W_DEFAULT = 32;

    typedef enum logic [1:0] {
        HZ_RUN      = 2'd0,
        HZ_MC_WAIT  = 2'd1,
        HZ_MEM_WAIT = 2'd2
    } hz_state_e;

    typedef struct packed {
        logic stall_if;
        logic stall_id;
        logic stall_ex;
        logic stall_mem;
        logic flush_id;
        logic clear_ex;
        logic clear_mem;
        logic clear_wb;
    } hz_ctrl_t;

    // x0 is hard-wired to zero, so a load targeting it never creates a hazard.
    function automatic logic load_use_hit(input logic [4:0] rs1,
                                          input logic [4:0] rs2,
                                          input logic       rs1_used,
                                          input logic       rs2_used,
                                          input logic [4:0] rd,
                                          input logic       is_load);
        return is_load && (rd != 5'd0) &&
               ((rs1_used && (rs1 == rd)) || (rs2_used && (rs2 == rd)));
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard sequencer bundle.
//  Pipeline-sourced: id_rs1/id_rs2/id_rs1_used/id_rs2_used, ex_rd, ex_is_load,
//                    ex_redirect, ex_mc_start, mc_done, dmem_req, dmem_ready
//  Sequencer-sourced: stall_if/id/ex/mem, flush_id, clear_ex/mem/wb, hang_err
//  modport master : pipeline side
//  modport slave  : hazard_ctrl side
interface hazard_ctrl_if;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_rs1_used;
    logic       id_rs2_used;
    logic [4:0] ex_rd;
    logic       ex_is_load;
    logic       ex_redirect;
    logic       ex_mc_start;
    logic       mc_done;
    logic       dmem_req;
    logic       dmem_ready;

    logic       stall_if;
    logic       stall_id;
    logic       stall_ex;
    logic       stall_mem;
    logic       flush_id;
    logic       clear_ex;
    logic       clear_mem;
    logic       clear_wb;
    logic       hang_err;

    modport master (
        output id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rd, ex_is_load,
               ex_redirect, ex_mc_start, mc_done, dmem_req, dmem_ready,
        input  stall_if, stall_id, stall_ex, stall_mem, flush_id, clear_ex,
               clear_mem, clear_wb, hang_err
    );

    modport slave (
        input  id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rd, ex_is_load,
               ex_redirect, ex_mc_start, mc_done, dmem_req, dmem_ready,
        output stall_if, stall_id, stall_ex, stall_mem, flush_id, clear_ex,
               clear_mem, clear_wb, hang_err
    );
endinterface

// File: rtl/hazard_ctrl_sat_counter.sv
// sat_counter: up-counter that sticks at all ones instead of wrapping.
//  clk   : clock, rising edge
//  rst   : asynchronous active-low reset, value -> 0
//  inc   : add one this cycle (ignored once saturated)
//  clr   : return to zero this cycle (wins over inc)
//  value : current count
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] value
);

    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] value_d;

    always_comb begin
        // NOTE: default assignment first so every path drives value_d (no latch).
        value_d = value_q;
        if (clr) begin
            value_d = '0;
        end else if (inc && (value_q != '1)) begin
            value_d = value_q + WIDTH'(1);
        end
    end

    // NOTE: non-blocking assignment in clocked logic so all flops update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencer for the 5-stage RV32 core.
//  Resolves data-memory wait states, multi-cycle EX ops, branch/jump redirects
//  and load-use hazards (in that priority) by driving hold/clear controls on
//  the PC and the four pipeline registers. A watchdog flags a freeze that
//  lasts WDOG_CYCLES-1 consecutive cycles via sticky hang_err.
//  Ports:
//   clk  : core clock, rising edge
//   rst  : asynchronous active-low reset
//   hz   : hazard_ctrl_if.slave (pipeline status in, controls + hang_err out)
//   perf_load_use/perf_flush/perf_freeze : saturating event counters, present
//          only when HAZARD_PERF_EN is defined
//  Parameters: WDOG_CYCLES (>= 2), PERF_W (only with HAZARD_PERF_EN)
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int WDOG_CYCLES = HZ_WDOG_DEFAULT
`ifdef HAZARD_PERF_EN
    , parameter int PERF_W    = HZ_PERF_W_DEFAULT
`endif
) (
    input  logic                clk,
    input  logic                rst,
    hazard_ctrl_if.slave        hz
`ifdef HAZARD_PERF_EN
    , output logic [PERF_W-1:0] perf_load_use
    , output logic [PERF_W-1:0] perf_flush
    , output logic [PERF_W-1:0] perf_freeze
`endif
);

    // The counter only has to reach WDOG_CYCLES-1, then saturates there.
    localparam int              WDOG_W    = $clog2(WDOG_CYCLES);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);

    hz_state_e         state_q;
    hz_state_e         state_d;
    hz_ctrl_t          ctrl;
    logic              mem_freeze;
    logic              mc_freeze;
    logic [WDOG_W-1:0] wdog_cnt;
    logic              hang_hit;
    logic              hang_q;
    logic              hang_d;

    assign mem_freeze = hz.dmem_req & ~hz.dmem_ready;
    assign mc_freeze  = hz.ex_mc_start & ~hz.mc_done;

    // A redirect or load-use that arrives during a freeze is simply not acted
    // on; EX is held, so the same request is still present when the freeze ends.
    always_comb begin
        ctrl    = '0;
        state_d = HZ_RUN;
        if (mem_freeze) begin
            ctrl.stall_if  = 1'b1;
            ctrl.stall_id  = 1'b1;
            ctrl.stall_ex  = 1'b1;
            ctrl.stall_mem = 1'b1;
            ctrl.clear_wb  = 1'b1;
            state_d        = HZ_MEM_WAIT;
        end else if (mc_freeze) begin
            ctrl.stall_if  = 1'b1;
            ctrl.stall_id  = 1'b1;
            ctrl.stall_ex  = 1'b1;
            ctrl.clear_mem = 1'b1;
            state_d        = HZ_MC_WAIT;
        end else if (hz.ex_redirect) begin
            ctrl.flush_id  = 1'b1;
            ctrl.clear_ex  = 1'b1;
        end else if (load_use_hit(hz.id_rs1, hz.id_rs2, hz.id_rs1_used,
                                  hz.id_rs2_used, hz.ex_rd, hz.ex_is_load)) begin
            ctrl.stall_if  = 1'b1;
            ctrl.stall_id  = 1'b1;
            ctrl.clear_ex  = 1'b1;
        end
        // Controls are combinational from the inputs, so reset must mask them
        // directly for them to drop the moment rst goes low.
        if (!rst) begin
            ctrl = '0;
        end
    end

    // Watchdog: counts every frozen cycle, cleared on the transition into RUN.
    sat_counter #(.WIDTH(WDOG_W)) u_wdog (
        .clk   (clk),
        .rst   (rst),
        .inc   (state_d != HZ_RUN),
        .clr   ((state_q != HZ_RUN) && (state_d == HZ_RUN)),
        .value (wdog_cnt)
    );

    assign hang_hit = (wdog_cnt >= WDOG_LAST);
    assign hang_d   = hang_q | hang_hit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= HZ_RUN;
            hang_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hang_q  <= hang_d;
        end
    end

    assign hz.stall_if  = ctrl.stall_if;
    assign hz.stall_id  = ctrl.stall_id;
    assign hz.stall_ex  = ctrl.stall_ex;
    assign hz.stall_mem = ctrl.stall_mem;
    assign hz.flush_id  = ctrl.flush_id;
    assign hz.clear_ex  = ctrl.clear_ex;
    assign hz.clear_mem = ctrl.clear_mem;
    assign hz.clear_wb  = ctrl.clear_wb;
    assign hz.hang_err  = hang_q | hang_hit;

`ifdef HAZARD_PERF_EN
    // Event decode from the controls: only a load-use bubble holds the front
    // end without holding EX; every freeze holds EX.
    sat_counter #(.WIDTH(PERF_W)) u_perf_load_use (
        .clk   (clk),
        .rst   (rst),
        .inc   (ctrl.stall_if & ~ctrl.stall_ex),
        .clr   (1'b0),
        .value (perf_load_use)
    );

    sat_counter #(.WIDTH(PERF_W)) u_perf_flush (
        .clk   (clk),
        .rst   (rst),
        .inc   (ctrl.flush_id),
        .clr   (1'b0),
        .value (perf_flush)
    );

    sat_counter #(.WIDTH(PERF_W)) u_perf_freeze (
        .clk   (clk),
        .rst   (rst),
        .inc   (ctrl.stall_ex),
        .clr   (1'b0),
        .value (perf_freeze)
    );
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl (watchdog built with WDOG_CYCLES = 8).
// Table of single-cycle vectors, hand-written multi-cycle sequences
// (load-use, multi-cycle op, mem wait with pending redirect, watchdog,
// reset mid-wait) and a randomized run against a rule-level reference model.
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

    localparam int WDOG = 8;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       ld;
        logic       redir;
        logic       mcs;
        logic       mcd;
        logic       req;
        logic       rdy;
    } in_t;

    typedef struct packed {
        in_t        in;
        logic [7:0] exp; // {stall_if,id,ex,mem, flush_id, clear_ex,mem,wb}
    } vec_t;

    logic clk;
    logic rst;
    hazard_ctrl_if hz_if ();

`ifdef HAZARD_PERF_EN
    logic [31:0] perf_load_use;
    logic [31:0] perf_flush;
    logic [31:0] perf_freeze;
`endif

    hazard_ctrl #(.WDOG_CYCLES(WDOG)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz_if)
`ifdef HAZARD_PERF_EN
        , .perf_load_use (perf_load_use)
        , .perf_flush    (perf_flush)
        , .perf_freeze   (perf_freeze)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int   errors = 0;
    int   checks = 0;
    in_t  cur;
    int   m_streak;
    logic m_hang;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic in_t mk(input int rs1, input int rs2, input bit u1, input bit u2,
                               input int rd, input bit ld, input bit redir, input bit mcs,
                               input bit mcd, input bit req, input bit rdy);
        in_t v;
        v.rs1 = 5'(rs1); v.rs2 = 5'(rs2); v.u1 = u1; v.u2 = u2; v.rd = 5'(rd);
        v.ld = ld; v.redir = redir; v.mcs = mcs; v.mcd = mcd; v.req = req; v.rdy = rdy;
        return v;
    endfunction

    // Rule-level reference: which hazard class wins this cycle, then its control set.
    function automatic bit model_frozen(input in_t v);
        return (v.req && !v.rdy) || (v.mcs && !v.mcd);
    endfunction

    function automatic logic [7:0] model_ctrl(input in_t v);
        bit uses_rd;
        uses_rd = 0;
        if (v.u1 && v.rs1 == v.rd) uses_rd = 1;
        if (v.u2 && v.rs2 == v.rd) uses_rd = 1;
        if (v.req && !v.rdy)                   return 8'b1111_0001;
        if (v.mcs && !v.mcd)                   return 8'b1110_0010;
        if (v.redir)                           return 8'b0000_1100;
        if (v.ld && v.rd != 0 && uses_rd)      return 8'b1100_0100;
        return 8'b0000_0000;
    endfunction

    function automatic logic [7:0] actual_ctrl();
        return {hz_if.stall_if, hz_if.stall_id, hz_if.stall_ex, hz_if.stall_mem,
                hz_if.flush_id, hz_if.clear_ex, hz_if.clear_mem, hz_if.clear_wb};
    endfunction

    task automatic drive(input in_t v);
        cur                  = v;
        hz_if.id_rs1         = v.rs1;
        hz_if.id_rs2         = v.rs2;
        hz_if.id_rs1_used    = v.u1;
        hz_if.id_rs2_used    = v.u2;
        hz_if.ex_rd          = v.rd;
        hz_if.ex_is_load     = v.ld;
        hz_if.ex_redirect    = v.redir;
        hz_if.ex_mc_start    = v.mcs;
        hz_if.mc_done        = v.mcd;
        hz_if.dmem_req       = v.req;
        hz_if.dmem_ready     = v.rdy;
        #2;
    endtask

    // Advance one clock; the model's watchdog view follows the same edge.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            m_streak = model_frozen(cur) ? m_streak + 1 : 0;
            if (m_streak >= WDOG - 1) m_hang = 1'b1;
        end
        #1;
    endtask

    task automatic check_model(input string name);
        check(name, 32'(actual_ctrl()), 32'(model_ctrl(cur)));
        check({name, "_hang"}, 32'(hz_if.hang_err), 32'(m_hang));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b0;
        m_streak = 0;
        m_hang   = 1'b0;
        drive(mk(0,0,0,0,0,0,0,0,0,0,0));
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    vec_t tbl [12];
    int   stall_cycles;

    initial begin
        rst      = 1'b0;
        m_streak = 0;
        m_hang   = 1'b0;
        drive(mk(0,0,0,0,0,0,0,0,0,0,0));
        #1;
        check("reset_ctrl", 32'(actual_ctrl()), 32'h0);
        check("reset_hang", 32'(hz_if.hang_err), 32'h0);
        check("reset_state", 32'(dut.state_q), 32'(HZ_RUN));
        #10;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // ---------------- single-cycle vector table ----------------
        //              rs1 rs2 u1 u2 rd ld rdr mcs mcd req rdy
        tbl[0]  = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 8'b0000_0000};
        tbl[1]  = '{mk(5, 0, 1, 0, 5, 1, 0, 0, 0, 0, 0), 8'b1100_0100};
        tbl[2]  = '{mk(0, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0), 8'b0000_0000};
        tbl[3]  = '{mk(1, 7, 1, 1, 7, 1, 0, 0, 0, 0, 0), 8'b1100_0100};
        tbl[4]  = '{mk(1, 7, 1, 0, 7, 1, 0, 0, 0, 0, 0), 8'b0000_0000};
        tbl[5]  = '{mk(5, 0, 1, 0, 5, 1, 1, 0, 0, 0, 0), 8'b0000_1100};
        tbl[6]  = '{mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), 8'b1110_0010};
        tbl[7]  = '{mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0), 8'b0000_0000};
        tbl[8]  = '{mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0), 8'b1111_0001};
        tbl[9]  = '{mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1), 8'b0000_1100};
        tbl[10] = '{mk(3, 3, 1, 1, 3, 1, 1, 1, 0, 1, 0), 8'b1111_0001};
        tbl[11] = '{mk(3, 3, 1, 1, 3, 1, 1, 1, 0, 1, 1), 8'b1110_0010};
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].in);
            check($sformatf("tbl%0d", i), 32'(actual_ctrl()), 32'(tbl[i].exp));
            tick();
        end

        // ---------------- load-use, then load drops; x0 never stalls ----------------
        do_reset();
        drive(mk(5, 0, 1, 0, 5, 1, 0, 0, 0, 0, 0));
        check("lu_stall", 32'(actual_ctrl()), 32'(8'b1100_0100));
        tick();
        drive(mk(5, 0, 1, 0, 5, 0, 0, 0, 0, 0, 0));
        check("lu_release", 32'(actual_ctrl()), 32'h0);
        tick();
        drive(mk(0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0));
        check("lu_x0", 32'(actual_ctrl()), 32'h0);
        tick();

        // ---------------- multi-cycle op: 3 stall cycles ----------------
        do_reset();
        stall_cycles = 0;
        for (int i = 0; i < 3; i++) begin
            drive(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
            check("mc_stall", 32'(actual_ctrl()), 32'(8'b1110_0010));
            if (hz_if.stall_if) stall_cycles++;
            tick();
            check("mc_state", 32'(dut.state_q), 32'(HZ_MC_WAIT));
        end
        drive(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
        check("mc_done", 32'(actual_ctrl()), 32'h0);
        if (hz_if.stall_if) stall_cycles++;
        tick();
        check("mc_stall_cycles", 32'(stall_cycles), 32'd3);
        check("mc_state_run", 32'(dut.state_q), 32'(HZ_RUN));
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tick();
        drive(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
        check("mc_start_done", 32'(actual_ctrl()), 32'h0);
        tick();
        check("mc_start_done_state", 32'(dut.state_q), 32'(HZ_RUN));

        // ---------------- mem wait with redirect held ----------------
        do_reset();
        for (int i = 0; i < 2; i++) begin
            drive(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0));
            check("memw_freeze", 32'(actual_ctrl()), 32'(8'b1111_0001));
            tick();
            check("memw_state", 32'(dut.state_q), 32'(HZ_MEM_WAIT));
        end
        drive(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1));
        check("memw_redirect", 32'(actual_ctrl()), 32'(8'b0000_1100));
        tick();
        check("memw_state_run", 32'(dut.state_q), 32'(HZ_RUN));

        // ---------------- watchdog ----------------
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
            check($sformatf("wdog_hang_%0d", i), 32'(hz_if.hang_err), 32'(i >= 7));
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
            check("wdog_sticky", 32'(hz_if.hang_err), 32'h1);
            check("wdog_ctrl", 32'(actual_ctrl()), 32'h0);
            tick();
        end
        do_reset();
        check("wdog_cleared", 32'(hz_if.hang_err), 32'h0);

        // ---------------- reset mid-MC_WAIT ----------------
        drive(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        tick();
        drive(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        check("rstmc_wait", 32'(dut.state_q), 32'(HZ_MC_WAIT));
        check("rstmc_stall", 32'(actual_ctrl()), 32'(8'b1110_0010));
        rst = 1'b0;
        #1;
        check("rstmc_ctrl", 32'(actual_ctrl()), 32'h0);
        check("rstmc_state", 32'(dut.state_q), 32'(HZ_RUN));
        check("rstmc_hang", 32'(hz_if.hang_err), 32'h0);
`ifdef HAZARD_PERF_EN
        check("rstmc_perf_lu", perf_load_use, 32'h0);
        check("rstmc_perf_flush", perf_flush, 32'h0);
        check("rstmc_perf_freeze", perf_freeze, 32'h0);
`endif
        m_streak = 0;
        m_hang   = 1'b0;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        rst = 1'b1;
        tick();

        // ---------------- randomized against reference model ----------------
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            in_t v;
            v.rs1   = 5'($urandom_range(0, 3));
            v.rs2   = 5'($urandom_range(0, 3));
            v.rd    = 5'($urandom_range(0, 3));
            v.u1    = 1'($urandom_range(0, 1));
            v.u2    = 1'($urandom_range(0, 1));
            v.ld    = 1'($urandom_range(0, 1));
            v.redir = ($urandom_range(0, 3) == 0);
            v.mcs   = ($urandom_range(0, 3) == 0);
            v.mcd   = 1'($urandom_range(0, 1));
            v.req   = ($urandom_range(0, 4) < 2);
            v.rdy   = ($urandom_range(0, 4) < 3);
            drive(v);
            check_model("rand");
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish by 200000");
        $fatal(1);
    end

endmodule
